// File: rtl/wb_unified_mem_arbiter.sv
// Two-to-one Wishbone arbiter that merges the core's instruction and data ports onto one
// unified-memory master, with one arbitration cycle per transfer, a transfer timeout and grant status.
module wb_unified_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] iwb_adr_i,
  input  logic                  iwb_cyc_i,
  input  logic                  iwb_stb_i,
  output logic [31:0]           iwb_dat_o,
  output logic                  iwb_ack_o,
  input  logic [ADDR_WIDTH-1:0] dwb_adr_i,
  input  logic [31:0]           dwb_dat_i,
  input  logic                  dwb_we_i,
  input  logic [3:0]            dwb_sel_i,
  input  logic                  dwb_cyc_i,
  input  logic                  dwb_stb_i,
  output logic [31:0]           dwb_dat_o,
  output logic                  dwb_ack_o,
  output logic                  dwb_err_o,
  output logic [ADDR_WIDTH-1:0] m_adr_o,
  output logic [31:0]           m_dat_o,
  output logic                  m_we_o,
  output logic [3:0]            m_sel_o,
  output logic                  m_cyc_o,
  output logic                  m_stb_o,
  input  logic [31:0]           m_dat_i,
  input  logic                  m_ack_i,
  input  logic                  m_err_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LIMIT = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [TW-1:0] r_timer;
  logic          r_rr_last_d;
  logic          r_timeout;

  logic w_req_i;
  logic w_req_d;
  logic w_granted;
  logic w_req_x;
  logic w_resp;
  logic w_timeout;
  logic w_done;

  assign w_req_i   = iwb_cyc_i & iwb_stb_i;
  assign w_req_d   = dwb_cyc_i & dwb_stb_i;
  assign w_granted = (r_state == GRANT_I) || (r_state == GRANT_D);
  assign w_req_x   = (r_state == GRANT_I) ? w_req_i :
                     (r_state == GRANT_D) ? w_req_d : 1'b0;
  assign w_resp    = m_ack_i | m_err_i;

  // A real response in the same cycle always beats the timeout; an abandoned request never times out.
  assign w_timeout = TIMEOUT_EN && w_granted && w_req_x && !w_resp && (r_timer == TIMER_LIMIT);
  assign w_done    = w_granted && (w_resp || w_timeout);

  assign grant_o   = {r_state == GRANT_D, r_state == GRANT_I};
  assign timeout_o = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_rr_last_d <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        r_timer <= '0;
      end else if (!w_resp) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_done) begin
        r_rr_last_d <= (r_state == GRANT_D);
      end
      if (w_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    m_adr_o      = '0;
    m_dat_o      = 32'h0;
    m_we_o       = 1'b0;
    m_sel_o      = 4'h0;
    m_cyc_o      = 1'b0;
    m_stb_o      = 1'b0;
    iwb_dat_o    = 32'h0;
    iwb_ack_o    = 1'b0;
    dwb_dat_o    = 32'h0;
    dwb_ack_o    = 1'b0;
    dwb_err_o    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_i && w_req_d) begin
          w_next_state = ((ARB_MODE == 0) || !r_rr_last_d) ? GRANT_D : GRANT_I;
        end else if (w_req_d) begin
          w_next_state = GRANT_D;
        end else if (w_req_i) begin
          w_next_state = GRANT_I;
        end
      end
      GRANT_I: begin
        m_adr_o   = iwb_adr_i;
        m_sel_o   = 4'hF;
        m_cyc_o   = w_req_x & ~w_timeout;
        m_stb_o   = w_req_x & ~w_timeout;
        // The fetch port has no error line: errors and timeouts complete with a zero (illegal) word.
        iwb_ack_o = w_resp | w_timeout;
        iwb_dat_o = (m_err_i | w_timeout) ? 32'h0 : m_dat_i;
        if (w_done || !w_req_x) begin
          w_next_state = IDLE;
        end
      end
      GRANT_D: begin
        m_adr_o   = dwb_adr_i;
        m_dat_o   = dwb_dat_i;
        m_we_o    = dwb_we_i;
        m_sel_o   = dwb_sel_i;
        m_cyc_o   = w_req_x & ~w_timeout;
        m_stb_o   = w_req_x & ~w_timeout;
        dwb_ack_o = m_ack_i & ~m_err_i;
        dwb_err_o = m_err_i | w_timeout;
        dwb_dat_o = m_dat_i;
        if (w_done || !w_req_x) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Self-checking bench: instance 0 runs fixed priority, instance 1 round-robin, both with an
// 8-cycle timeout; directed scenarios followed by randomized traffic against a transfer-level model.
module tb_wb_unified_mem_arbiter;

  localparam int TO    = 8;
  localparam int NONE  = 0;
  localparam int INSTR = 1;
  localparam int DATA  = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] iwbAdr[2];
  logic        iwbCyc[2];
  logic        iwbStb[2];
  logic [31:0] iwbDat[2];
  logic        iwbAck[2];
  logic [31:0] dwbAdr[2];
  logic [31:0] dwbDatIn[2];
  logic        dwbWe[2];
  logic [3:0]  dwbSel[2];
  logic        dwbCyc[2];
  logic        dwbStb[2];
  logic [31:0] dwbDatOut[2];
  logic        dwbAck[2];
  logic        dwbErr[2];
  logic [31:0] mAdr[2];
  logic [31:0] mDatOut[2];
  logic        mWe[2];
  logic [3:0]  mSel[2];
  logic        mCyc[2];
  logic        mStb[2];
  logic [31:0] mDatIn[2];
  logic        mAck[2];
  logic        mErr[2];
  logic [1:0]  grant[2];
  logic        timeoutFlag[2];

  // Transfer-level model: who owns the bus, how long it has waited, who won last, sticky timeout.
  int owner[2];
  int waited[2];
  int lastWon[2];
  bit sticky[2];

  int checks;
  int failures;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    wb_unified_mem_arbiter #(
      .ADDR_WIDTH    (32),
      .ARB_MODE      (k),
      .TIMEOUT_CYCLES(TO)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .iwb_adr_i(iwbAdr[k]),
      .iwb_cyc_i(iwbCyc[k]),
      .iwb_stb_i(iwbStb[k]),
      .iwb_dat_o(iwbDat[k]),
      .iwb_ack_o(iwbAck[k]),
      .dwb_adr_i(dwbAdr[k]),
      .dwb_dat_i(dwbDatIn[k]),
      .dwb_we_i (dwbWe[k]),
      .dwb_sel_i(dwbSel[k]),
      .dwb_cyc_i(dwbCyc[k]),
      .dwb_stb_i(dwbStb[k]),
      .dwb_dat_o(dwbDatOut[k]),
      .dwb_ack_o(dwbAck[k]),
      .dwb_err_o(dwbErr[k]),
      .m_adr_o  (mAdr[k]),
      .m_dat_o  (mDatOut[k]),
      .m_we_o   (mWe[k]),
      .m_sel_o  (mSel[k]),
      .m_cyc_o  (mCyc[k]),
      .m_stb_o  (mStb[k]),
      .m_dat_i  (mDatIn[k]),
      .m_ack_i  (mAck[k]),
      .m_err_i  (mErr[k]),
      .grant_o  (grant[k]),
      .timeout_o(timeoutFlag[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      owner[k]   = NONE;
      waited[k]  = 0;
      lastWon[k] = INSTR;
      sticky[k]  = 1'b0;
    end
  endtask

  // Drives one instance's core and slave inputs for the current cycle.
  task automatic applyStimulus(input int k, input bit iReq, input logic [31:0] iAdr,
                               input bit dReq, input logic [31:0] dAdr, input logic [31:0] dDat,
                               input bit dWe, input logic [3:0] dSel,
                               input bit ack, input bit err, input logic [31:0] sDat);
    iwbCyc[k]   = iReq;
    iwbStb[k]   = iReq;
    iwbAdr[k]   = iAdr;
    dwbCyc[k]   = dReq;
    dwbStb[k]   = dReq;
    dwbAdr[k]   = dAdr;
    dwbDatIn[k] = dDat;
    dwbWe[k]    = dWe;
    dwbSel[k]   = dSel;
    mAck[k]     = ack;
    mErr[k]     = err;
    mDatIn[k]   = sDat;
    #1;
  endtask

  task automatic idleBoth();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
  endtask

  // Compares both instances against the model mid-cycle, then advances the model across the edge.
  task automatic checkOutput();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit          reqI;
      bit          reqD;
      bit          myReq;
      bit          resp;
      bit          expired;
      bit          drive;
      logic [70:0] expM;
      logic [32:0] expI;
      logic [33:0] expD;
      logic [1:0]  expG;
      reqI    = iwbCyc[k] && iwbStb[k];
      reqD    = dwbCyc[k] && dwbStb[k];
      myReq   = (owner[k] == INSTR) ? reqI : (owner[k] == DATA) ? reqD : 1'b0;
      resp    = mAck[k] || mErr[k];
      expired = (owner[k] != NONE) && myReq && !resp && (waited[k] + 1 == TO);
      drive   = myReq && !expired;
      expM    = '0;
      expI    = '0;
      expD    = '0;
      expG    = (owner[k] == DATA) ? 2'b10 : (owner[k] == INSTR) ? 2'b01 : 2'b00;
      if (owner[k] == INSTR) begin
        expM = {iwbAdr[k], 32'h0, 1'b0, 4'hF, drive, drive};
        expI = {resp || expired, (mErr[k] || expired) ? 32'h0 : mDatIn[k]};
      end else if (owner[k] == DATA) begin
        expM = {dwbAdr[k], dwbDatIn[k], dwbWe[k], dwbSel[k], drive, drive};
        expD = {mAck[k] && !mErr[k], mErr[k] || expired, mDatIn[k]};
      end
      check($sformatf("i%0d_master", k),
            {mAdr[k], mDatOut[k], mWe[k], mSel[k], mCyc[k], mStb[k]}, expM);
      check($sformatf("i%0d_iport", k), {iwbAck[k], iwbDat[k]}, expI);
      check($sformatf("i%0d_dport", k), {dwbAck[k], dwbErr[k], dwbDatOut[k]}, expD);
      check($sformatf("i%0d_grant", k), grant[k], expG);
      check($sformatf("i%0d_timeout", k), timeoutFlag[k], sticky[k]);
      if (owner[k] == NONE) begin
        waited[k] = 0;
        if (reqI && reqD) begin
          owner[k] = (k == 0) ? DATA : ((lastWon[k] == DATA) ? INSTR : DATA);
        end else if (reqD) begin
          owner[k] = DATA;
        end else if (reqI) begin
          owner[k] = INSTR;
        end
      end else if (resp || expired) begin
        lastWon[k] = owner[k];
        sticky[k]  = sticky[k] | expired;
        owner[k]   = NONE;
      end else if (!myReq) begin
        owner[k] = NONE;
      end else begin
        waited[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    resetModel();
    idleBoth();
    #11;
    check("reset_grant0", grant[0], 2'b00);
    check("reset_grant1", grant[1], 2'b00);
    check("reset_bus0", {mCyc[0], mStb[0], timeoutFlag[0]}, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lone fetch acknowledged one cycle after the strobe.
    applyStimulus(0, 1, 32'h100, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    check("t1_c0_grant", grant[0], 2'b00);
    check("t1_c0_stb", mStb[0], 1'b0);
    checkOutput();
    applyStimulus(0, 1, 32'h100, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    check("t1_c1_stb_adr", {mStb[0], mAdr[0]}, {1'b1, 32'h100});
    checkOutput();
    applyStimulus(0, 1, 32'h100, 0, 0, 0, 0, 4'h0, 1, 0, 32'h0000_0013);
    check("t1_c2_iack", {iwbAck[0], iwbDat[0], dwbAck[0]}, {1'b1, 32'h0000_0013, 1'b0});
    checkOutput();
    idleBoth();
    checkOutput();

    // Tie under fixed priority: data first, an idle cycle, then instruction.
    applyStimulus(0, 1, 32'h200, 1, 32'h300, 0, 0, 4'hF, 1, 0, 32'h55);
    check("t2_c0_grant", grant[0], 2'b00);
    checkOutput();
    applyStimulus(0, 1, 32'h200, 1, 32'h300, 0, 0, 4'hF, 1, 0, 32'h55);
    check("t2_c1_grant", {grant[0], dwbAck[0], iwbAck[0]}, {2'b10, 1'b1, 1'b0});
    checkOutput();
    applyStimulus(0, 1, 32'h200, 0, 0, 0, 0, 4'h0, 1, 0, 32'h66);
    check("t2_c2_grant", grant[0], 2'b00);
    checkOutput();
    applyStimulus(0, 1, 32'h200, 0, 0, 0, 0, 4'h0, 1, 0, 32'h66);
    check("t2_c3_grant", {grant[0], iwbAck[0]}, {2'b01, 1'b1});
    checkOutput();
    idleBoth();
    checkOutput();

    // Round-robin ties alternate starting with data.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 32'h400 + i, 1, 32'h800 + i, 0, 0, 4'hF, 1, 0, 32'h77);
      if (i % 2 == 0) begin
        check($sformatf("t3_c%0d_grant", i), grant[1], 2'b00);
      end else begin
        check($sformatf("t3_c%0d_grant", i), grant[1], ((i / 2) % 2 == 0) ? 2'b10 : 2'b01);
      end
      checkOutput();
    end
    idleBoth();
    checkOutput();

    // Byte store mirrored to the master while a fetch waits its turn.
    applyStimulus(0, 1, 32'h104, 1, 32'h1000, 32'hAB, 1, 4'b0001, 0, 0, 0);
    check("t4_c0_grant", grant[0], 2'b00);
    checkOutput();
    applyStimulus(0, 1, 32'h104, 1, 32'h1000, 32'hAB, 1, 4'b0001, 0, 0, 0);
    check("t4_c1_mirror", {mAdr[0], mDatOut[0], mWe[0], mSel[0], mCyc[0]},
          {32'h1000, 32'hAB, 1'b1, 4'b0001, 1'b1});
    checkOutput();
    applyStimulus(0, 1, 32'h104, 1, 32'h1000, 32'hAB, 1, 4'b0001, 1, 0, 0);
    check("t4_c2_dack", {grant[0], dwbAck[0], iwbAck[0]}, {2'b10, 1'b1, 1'b0});
    checkOutput();
    applyStimulus(0, 1, 32'h104, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    check("t4_c3_idle", {grant[0], iwbAck[0]}, {2'b00, 1'b0});
    checkOutput();
    applyStimulus(0, 1, 32'h104, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    check("t4_c4_fetch", {grant[0], mWe[0], mSel[0], mAdr[0]}, {2'b01, 1'b0, 4'hF, 32'h104});
    checkOutput();
    applyStimulus(0, 1, 32'h104, 0, 0, 0, 0, 4'h0, 1, 0, 32'h1234_5678);
    check("t4_c5_iack", {iwbAck[0], iwbDat[0]}, {1'b1, 32'h1234_5678});
    checkOutput();
    idleBoth();
    checkOutput();

    // Data read that is never answered times out in its eighth granted cycle.
    for (int i = 0; i <= 8; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h2000, 0, 0, 4'hF, 0, 0, 0);
      if (i == 8) begin
        check("t5_fire", {dwbErr[0], dwbAck[0], mCyc[0], mStb[0]}, 4'b1000);
      end else if (i > 0) begin
        check($sformatf("t5_wait%0d", i), {dwbErr[0], mCyc[0]}, 2'b01);
      end
      checkOutput();
    end
    idleBoth();
    check("t5_sticky_a", {timeoutFlag[0], grant[0]}, 3'b100);
    checkOutput();
    idleBoth();
    check("t5_sticky_b", timeoutFlag[0], 1'b1);
    checkOutput();

    // Asynchronous reset in the middle of a data grant.
    applyStimulus(0, 0, 0, 1, 32'h3000, 0, 0, 4'hF, 0, 0, 0);
    checkOutput();
    applyStimulus(0, 0, 0, 1, 32'h3000, 0, 0, 4'hF, 0, 0, 0);
    check("t6_granted", grant[0], 2'b10);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {grant[0], mCyc[0], mStb[0], mAdr[0], dwbErr[0], timeoutFlag[0]},
          {2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
    resetModel();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 1, 32'h500, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    checkOutput();
    applyStimulus(0, 1, 32'h500, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    check("t6_regrant", {grant[0], mStb[0], mAdr[0]}, {2'b01, 1'b1, 32'h500});
    checkOutput();
    applyStimulus(0, 1, 32'h500, 0, 0, 0, 0, 4'h0, 1, 0, 32'h9);
    checkOutput();
    idleBoth();
    checkOutput();

    // Randomized traffic, with periodic silent-slave windows to force timeouts.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        bit mute;
        mute        = (c % 60) >= 44;
        iwbCyc[k]   = mute ? 1'b1 : ($urandom_range(0, 9) < 7);
        iwbStb[k]   = mute ? 1'b1 : ($urandom_range(0, 9) < 8);
        dwbCyc[k]   = mute ? 1'b1 : ($urandom_range(0, 9) < 7);
        dwbStb[k]   = mute ? 1'b1 : ($urandom_range(0, 9) < 8);
        iwbAdr[k]   = $urandom;
        dwbAdr[k]   = $urandom;
        dwbDatIn[k] = $urandom;
        dwbWe[k]    = $urandom_range(0, 1) == 1;
        dwbSel[k]   = 4'($urandom_range(0, 15));
        mAck[k]     = mute ? 1'b0 : ($urandom_range(0, 9) < 3);
        mErr[k]     = mute ? 1'b0 : ($urandom_range(0, 19) == 0);
        mDatIn[k]   = $urandom;
      end
      #1;
      checkOutput();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
